// File: rtl/lenet5_layer_sched.sv
// rtl/lenet5_layer_sched.sv - time-multiplexed LeNet-5 step sequencer for one shared compute engine
// Optional per-step watchdog and ERR state enabled by defining LAYER_TIMEOUT_EN.
module lenet5_layer_sched #(
  parameter int NUM_STEPS      = 11,
  parameter int STEP_W         = 4,
  parameter int CNT_W          = 20,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_valid,
  output logic              frame_ready,
  input  logic              abort,
  output logic              eng_start,
  output logic [STEP_W-1:0] eng_step,
  output logic [1:0]        eng_op,
  output logic              eng_src_buf,
  output logic              eng_dst_buf,
  input  logic              eng_done,
  output logic              eng_abort,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              result_buf,
  output logic              busy,
  output logic [CNT_W-1:0]  last_frame_cycles,
  output logic              err
);

  if (STEP_W < $clog2(NUM_STEPS) || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("lenet5_layer_sched: inconsistent parameters");
  end

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_ERR} state_e;

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              buf_sel_q, buf_sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  last_q, last_d;
  logic              rbuf_q, rbuf_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              active;

  // C1,T1,S2,C3,T2,S4,C5,T3,F6,T4,OUT
  function automatic logic [1:0] op_of(input logic [STEP_W-1:0] s);
    case (int'(s))
      0, 3:       op_of = 2'd0;
      1, 4, 7, 9: op_of = 2'd1;
      2, 5:       op_of = 2'd2;
      default:    op_of = 2'd3;
    endcase
  endfunction

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef LAYER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d, wd_inc;
  logic            err_pulse_q, err_pulse_d;

  assign wd_inc = wd_q + WD_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q        <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      wd_q        <= wd_d;
      err_pulse_q <= err_pulse_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      step_q    <= '0;
      buf_sel_q <= 1'b0;
      cnt_q     <= '0;
      last_q    <= '0;
      rbuf_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      buf_sel_q <= buf_sel_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      rbuf_q    <= rbuf_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    buf_sel_d    = buf_sel_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    rbuf_d       = rbuf_q;
    frame_ready  = 1'b0;
    eng_start    = 1'b0;
    eng_abort    = 1'b0;
    result_valid = 1'b0;
    result_buf   = 1'b0;
    err          = 1'b0;
    active       = 1'b0;
`ifdef LAYER_TIMEOUT_EN
    wd_d        = wd_q;
    err_pulse_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        frame_ready = 1'b1;
        if (frame_valid) begin
          step_d    = '0;
          buf_sel_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        active    = 1'b1;
        eng_start = 1'b1;
        cnt_d     = cnt_inc;
`ifdef LAYER_TIMEOUT_EN
        wd_d = '0;
`endif
        if (abort) begin
          eng_abort = 1'b1;
          state_d   = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        active = 1'b1;
        cnt_d  = cnt_inc;
        if (abort) begin
          eng_abort = 1'b1;
          state_d   = S_IDLE;
        end else if (eng_done) begin
          if (step_q == STEP_W'(NUM_STEPS - 1)) begin
            // Latched count includes this final WAIT cycle.
            rbuf_d  = ~buf_sel_q;
            last_d  = cnt_inc;
            state_d = S_DONE;
          end else begin
            step_d    = step_q + STEP_W'(1);
            buf_sel_d = ~buf_sel_q;
            state_d   = S_ISSUE;
          end
        end
`ifdef LAYER_TIMEOUT_EN
        else begin
          wd_d = wd_inc;
          if (wd_inc == WD_W'(TIMEOUT_CYCLES)) begin
            err_pulse_d = 1'b1;
            state_d     = S_ERR;
          end
        end
`endif
      end
      S_DONE: begin
        result_valid = 1'b1;
        result_buf   = rbuf_q;
        if (abort || result_ready) state_d = S_IDLE;
      end
`ifdef LAYER_TIMEOUT_EN
      S_ERR: begin
        err       = 1'b1;
        eng_abort = err_pulse_q;
        if (abort) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Engine-facing step info is only presented while a step is in flight.
  assign eng_step          = active ? step_q : '0;
  assign eng_op            = active ? op_of(step_q) : 2'd0;
  assign eng_src_buf       = active & buf_sel_q;
  assign eng_dst_buf       = active & ~buf_sel_q;
  assign busy              = (state_q != S_IDLE);
  assign last_frame_cycles = last_q;

endmodule
